// File: rtl/image_filter_pkg.sv
// rtl/image_filter_pkg.sv - mode encodings and sizing helpers for image_window_filter
//
// Purpose : Shared definitions for the K x K binary neighbourhood filter:
//           the 2-bit filter mode type and constant-function helpers used
//           to size the column address and the popcount/threshold width.
// Ports   : none (package)
package image_filter_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_ERODE  = 2'b01,
    MODE_DILATE = 2'b10,
    MODE_EDGE   = 2'b11
  } mode_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Address width for n entries, never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - (K-1) line history store for the window filter
//
// Purpose : Holds the previous ROWS lines of binary pixels, one ROWS-bit word
//           per column. Each access reads the column word and writes it back
//           shifted by one line with the new pixel entering at bit 0, so bit i
//           always holds the pixel i+1 lines above the incoming one.
//           Contents are not reset; the top level masks rows that predate
//           the current frame.
// Ports   : i_clk    pixel clock
//           i_addr   column address (read and write)
//           i_we     write the shifted word back at i_addr
//           i_din    incoming pixel for the newest line
//           o_rdata  column word before this cycle's write
module window_line_buffer
  import image_filter_pkg::*;
#(
  parameter int LINE_W = 1024,
  parameter int ROWS   = 2,
  parameter int ADDR_W = addr_width(LINE_W)
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic              i_din,
  output logic [ROWS-1:0]   o_rdata
);

  logic [ROWS-1:0] r_mem [LINE_W];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= {o_rdata[ROWS-2:0], i_din};
    end
  end

endmodule

// File: rtl/image_window_filter.sv
// rtl/image_window_filter.sv - streaming K x K binary morphological window filter
//
// Purpose : Takes one binary pixel per vde cycle, keeps K-1 lines in a line
//           buffer, builds a K x K window and emits pass / erode / dilate /
//           edge of the window centre two cycles after the pixel arrives.
//           Also reports the window popcount and a popcount threshold flag,
//           and a sticky overflow when a line runs past LINE_W pixels.
// Config  : IMAGE_WINDOW_FILTER_COUNT_EN - when defined, cnt_out/cnt_ge carry
//           the window popcount and cnt_out >= thresh; when undefined both
//           are tied to 0 and thresh is ignored.
// Ports   : CLK        pixel clock
//           RST_N      asynchronous reset, active low
//           vsync      single-cycle frame-start pulse
//           vde        pixel valid
//           bin_in     binary input pixel
//           mode       00 pass, 01 erode, 10 dilate, 11 edge
//           thresh     popcount threshold
//           bin_out    filter result
//           cnt_out    number of ones in the window
//           cnt_ge     cnt_out >= thresh
//           out_valid  vde delayed by two cycles
//           overflow   sticky line-overflow flag, cleared by vsync
module image_window_filter
  import image_filter_pkg::*;
#(
  parameter int LINE_W = 1024,
  parameter int K      = 3,
  parameter int CNT_W  = clog2(K * K + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             vsync,
  input  logic             vde,
  input  logic             bin_in,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] thresh,
  output logic             bin_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_ge,
  output logic             out_valid,
  output logic             overflow
);

  localparam int H     = K / 2;
  localparam int ROWS  = K - 1;
  localparam int COL_W = addr_width(LINE_W);
  localparam int ROW_W = addr_width(K);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(K - 1);

  // Input-side state
  logic             r_vde_d1;
  logic [COL_W-1:0] r_col;
  logic             r_full;
  logic [ROW_W-1:0] r_row;
  logic             r_first;
  logic             r_ovf;
  logic [K*K-1:0]   r_win;

  // Output-stage state
  logic             r_bin;
  logic             r_out_vld;

  logic             w_ls;
  logic [COL_W-1:0] w_col;
  logic             w_full;
  logic             w_we;
  logic [ROW_W-1:0] w_row;
  logic             w_first;
  logic [ROWS-1:0]  w_rdata;
  logic [K-1:0]     w_raw;
  logic [K-1:0]     w_colvec;
  mode_t            w_mode;
  logic             w_centre;
  logic             w_erode;
  logic             w_dilate;
  logic             w_result;

  // Line start is the first vde cycle after a gap.
  assign w_ls = vde & ~r_vde_d1;

  // The first pixel of a line uses column 0 regardless of where the previous
  // line left the counter. r_full marks that column LINE_W-1 has been written,
  // so any further pixel on this line is an overflow.
  assign w_col  = w_ls ? '0 : r_col;
  assign w_full = w_ls ? 1'b0 : r_full;
  assign w_we   = vde & ~w_full;

  // Row of the current pixel. vsync takes priority; when it lands on a line
  // start that line is already row 0, so first_line is consumed immediately.
  always_comb begin
    w_row   = r_row;
    w_first = r_first;
    if (vsync) begin
      w_row   = '0;
      w_first = ~w_ls;
    end else if (w_ls) begin
      if (r_first) begin
        w_first = 1'b0;
      end else if (r_row != LAST_ROW) begin
        w_row = r_row + ROW_W'(1);
      end
    end
  end

  window_line_buffer #(
    .LINE_W (LINE_W),
    .ROWS   (ROWS),
    .ADDR_W (COL_W)
  ) u_line_buffer (
    .i_clk   (CLK),
    .i_addr  (w_col),
    .i_we    (w_we),
    .i_din   (bin_in),
    .o_rdata (w_rdata)
  );

  // Column vector entry j is the pixel j lines above; entries above the
  // first line of the frame read stale buffer data and are forced to 0.
  assign w_raw = {w_rdata, bin_in};

  always_comb begin
    w_colvec = '0;
    for (int j = 0; j < K; j++) begin
      w_colvec[j] = w_raw[j] & (j <= int'(w_row));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vde_d1 <= 1'b0;
      r_col    <= '0;
      r_full   <= 1'b0;
      r_row    <= '0;
      r_first  <= 1'b1;
      r_ovf    <= 1'b0;
      r_win    <= '0;
    end else begin
      r_vde_d1 <= vde;
      r_row    <= w_row;
      r_first  <= w_first;
      if (vde) begin
        if (w_col == LAST_COL) begin
          r_col  <= w_col;
          r_full <= 1'b1;
        end else begin
          r_col  <= w_col + COL_W'(1);
          r_full <= 1'b0;
        end
        // Window columns: bits [0 +: K] newest column, [K +: K] one left, ...
        // Clearing on line start gives a zero left border.
        if (w_ls) begin
          r_win <= {{(K*K-K){1'b0}}, w_colvec};
        end else begin
          r_win <= {r_win[K*K-K-1:0], w_colvec};
        end
      end
      if (vsync) begin
        r_ovf <= 1'b0;
      end else if (vde & w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Output stage: r_vde_d1 marks a window that was updated last cycle.
  assign w_mode   = mode_t'(mode);
  assign w_centre = r_win[H*K+H];
  assign w_erode  = &r_win;
  assign w_dilate = |r_win;

  always_comb begin
    w_result = w_centre;
    case (w_mode)
      MODE_PASS:   w_result = w_centre;
      MODE_ERODE:  w_result = w_erode;
      MODE_DILATE: w_result = w_dilate;
      MODE_EDGE:   w_result = w_centre & ~w_erode;
      default:     w_result = w_centre;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_vld <= 1'b0;
      r_bin     <= 1'b0;
    end else begin
      r_out_vld <= r_vde_d1;
      if (r_vde_d1) begin
        r_bin <= w_result;
      end
    end
  end

`ifdef IMAGE_WINDOW_FILTER_COUNT_EN
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cnt_ge;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < K * K; i++) begin
      w_cnt = w_cnt + CNT_W'(r_win[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt    <= '0;
      r_cnt_ge <= 1'b0;
    end else if (r_vde_d1) begin
      r_cnt    <= w_cnt;
      r_cnt_ge <= (w_cnt >= thresh);
    end
  end

  assign cnt_out = r_cnt;
  assign cnt_ge  = r_cnt_ge;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^thresh;
  assign cnt_out = '0;
  assign cnt_ge  = 1'b0;
`endif

  assign bin_out   = r_bin;
  assign out_valid = r_out_vld;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_image_window_filter.sv
// tb/tb_image_window_filter.sv - self-checking bench for image_window_filter (K=3, LINE_W=8)
module tb_image_window_filter;

  localparam int K      = 3;
  localparam int H      = K / 2;
  localparam int LINE_W = 8;
  localparam int CNT_W  = 4;
`ifdef IMAGE_WINDOW_FILTER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             CLK;
  logic             RST_N;
  logic             vsync;
  logic             vde;
  logic             bin_in;
  logic [1:0]       mode;
  logic [CNT_W-1:0] thresh;
  logic             bin_out;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_ge;
  logic             out_valid;
  logic             overflow;

  int n_assert = 0;
  int n_fail   = 0;

  bit             img [0:9][0:9];
  logic           q_bin [$];
  logic [CNT_W-1:0] q_cnt [$];
  logic           q_ge  [$];

  image_window_filter #(
    .LINE_W (LINE_W),
    .K      (K)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .vsync     (vsync),
    .vde       (vde),
    .bin_in    (bin_in),
    .mode      (mode),
    .thresh    (thresh),
    .bin_out   (bin_out),
    .cnt_out   (cnt_out),
    .cnt_ge    (cnt_ge),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic int win_count(input int r, input int c);
    int n;
    n = 0;
    for (int dr = 0; dr < K; dr++)
      for (int dc = 0; dc < K; dc++)
        if (r - dr >= 0 && c - dc >= 0) n += int'(img[r-dr][c-dc]);
    return n;
  endfunction

  function automatic logic exp_bin(input int m, input int r, input int c);
    int   n;
    logic ctr;
    n   = win_count(r, c);
    ctr = (r >= H && c >= H) ? img[r-H][c-H] : 1'b0;
    case (m)
      0:       return ctr;
      1:       return (n == K * K);
      2:       return (n > 0);
      default: return ctr && (n != K * K);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    return CNT_EN ? CNT_W'(n) : '0;
  endfunction

  function automatic logic exp_ge(input int n, input int th);
    return CNT_EN ? (n >= th) : 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
    if (out_valid === 1'b1) begin
      q_bin.push_back(bin_out);
      q_cnt.push_back(cnt_out);
      q_ge.push_back(cnt_ge);
    end
  endtask

  task automatic clear_img();
    foreach (img[r, c]) img[r][c] = 1'b0;
  endtask

  task automatic drive_frame(input int rows, input int width);
    q_bin.delete();
    q_cnt.delete();
    q_ge.delete();
    vsync = 1'b1; vde = 1'b0; bin_in = 1'b0;
    step();
    vsync = 1'b0;
    for (int r = 0; r < rows; r++) begin
      vde = 1'b0;
      step();
      step();
      for (int c = 0; c < width; c++) begin
        vde    = 1'b1;
        bin_in = img[r][c];
        step();
      end
    end
    vde = 1'b0; bin_in = 1'b0;
    repeat (4) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic prev;
    RST_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vsync = 1'($urandom); vde = 1'($urandom); bin_in = 1'($urandom);
      mode = 2'($urandom); thresh = CNT_W'($urandom);
      step();
      n_assert++;
      if ({bin_out, cnt_out, cnt_ge, out_valid, overflow} !== 8'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got %b need 00000000", i,
                 {bin_out, cnt_out, cnt_ge, out_valid, overflow});
      end
    end
    vsync = 1'b0; vde = 1'b0;
    step();
    RST_N = 1'b1;
    prev  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic v;
      v = 1'($urandom);
      vde = v; bin_in = 1'($urandom);
      step();
      n_assert++;
      if (out_valid !== prev) begin
        n_fail++;
        $display("FAIL valid_delay step %0d got %b need %b", i, out_valid, prev);
      end
      prev = v;
    end
    vde = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_dilate();
    clear_img();
    img[2][3] = 1'b1;
    mode = 2'b10; thresh = 4'd1;
    drive_frame(8, 8);
    n_assert++;
    if (q_bin.size() != 64) begin
      n_fail++; $display("FAIL dilate_len got %0d need 64", q_bin.size());
    end
    for (int k = 0; k < q_bin.size() && k < 64; k++) begin
      int r; int c; int n; logic eb;
      r = k / 8; c = k % 8; n = win_count(r, c); eb = exp_bin(2, r, c);
      n_assert++;
      if (q_bin[k] !== eb) begin n_fail++; $display("FAIL dilate_bin r%0d c%0d got %b need %b", r, c, q_bin[k], eb); end
      n_assert++;
      if (q_cnt[k] !== exp_cnt(n)) begin n_fail++; $display("FAIL dilate_cnt r%0d c%0d got %0d need %0d", r, c, q_cnt[k], exp_cnt(n)); end
      n_assert++;
      if (q_ge[k] !== exp_ge(n, 1)) begin n_fail++; $display("FAIL dilate_ge r%0d c%0d got %b need %b", r, c, q_ge[k], exp_ge(n, 1)); end
    end
  endtask

  task automatic test_erode();
    foreach (img[r, c]) img[r][c] = 1'b1;
    mode = 2'b01; thresh = 4'd9;
    drive_frame(8, 8);
    n_assert++;
    if (q_bin.size() != 64) begin
      n_fail++; $display("FAIL erode_len got %0d need 64", q_bin.size());
    end
    for (int k = 0; k < q_bin.size() && k < 64; k++) begin
      int r; int c; int n; logic eb;
      r = k / 8; c = k % 8; n = win_count(r, c); eb = exp_bin(1, r, c);
      n_assert++;
      if (q_bin[k] !== eb) begin n_fail++; $display("FAIL erode_bin r%0d c%0d got %b need %b", r, c, q_bin[k], eb); end
      n_assert++;
      if (q_cnt[k] !== exp_cnt(n)) begin n_fail++; $display("FAIL erode_cnt r%0d c%0d got %0d need %0d", r, c, q_cnt[k], exp_cnt(n)); end
      n_assert++;
      if (q_ge[k] !== exp_ge(n, 9)) begin n_fail++; $display("FAIL erode_ge r%0d c%0d got %b need %b", r, c, q_ge[k], exp_ge(n, 9)); end
    end
  endtask

  task automatic test_edge();
    clear_img();
    for (int r = 2; r <= 5; r++)
      for (int c = 2; c <= 5; c++) img[r][c] = 1'b1;
    mode = 2'b11; thresh = 4'd3;
    drive_frame(8, 8);
    n_assert++;
    if (q_bin.size() != 64) begin
      n_fail++; $display("FAIL edge_len got %0d need 64", q_bin.size());
    end
    for (int k = 0; k < q_bin.size() && k < 64; k++) begin
      int r; int c; int n; logic eb;
      r = k / 8; c = k % 8; n = win_count(r, c); eb = exp_bin(3, r, c);
      n_assert++;
      if (q_bin[k] !== eb) begin n_fail++; $display("FAIL edge_bin r%0d c%0d got %b need %b", r, c, q_bin[k], eb); end
      n_assert++;
      if (q_cnt[k] !== exp_cnt(n)) begin n_fail++; $display("FAIL edge_cnt r%0d c%0d got %0d need %0d", r, c, q_cnt[k], exp_cnt(n)); end
    end
  endtask

  task automatic test_count_threshold();
    foreach (img[r, c]) img[r][c] = ((r + c) % 2 == 0);
    mode = 2'b00; thresh = 4'd5;
    drive_frame(8, 8);
    n_assert++;
    if (q_bin.size() != 64) begin
      n_fail++; $display("FAIL count_len got %0d need 64", q_bin.size());
    end
    for (int k = 0; k < q_bin.size() && k < 64; k++) begin
      int r; int c; int n; logic eb;
      r = k / 8; c = k % 8; n = win_count(r, c); eb = exp_bin(0, r, c);
      n_assert++;
      if (q_bin[k] !== eb) begin n_fail++; $display("FAIL count_bin r%0d c%0d got %b need %b", r, c, q_bin[k], eb); end
      n_assert++;
      if (q_cnt[k] !== exp_cnt(n)) begin n_fail++; $display("FAIL count_cnt r%0d c%0d got %0d need %0d", r, c, q_cnt[k], exp_cnt(n)); end
      n_assert++;
      if (q_ge[k] !== exp_ge(n, 5)) begin n_fail++; $display("FAIL count_ge r%0d c%0d got %b need %b", r, c, q_ge[k], exp_ge(n, 5)); end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) begin
      int rows; int width; int m; int th;
      rows = $urandom_range(3, 8); width = $urandom_range(3, 8);
      m = $urandom_range(0, 3); th = $urandom_range(0, 9);
      foreach (img[r, c]) img[r][c] = 1'($urandom);
      mode = 2'(m); thresh = CNT_W'(th);
      drive_frame(rows, width);
      n_assert++;
      if (q_bin.size() != rows * width) begin
        n_fail++; $display("FAIL random_len frame %0d got %0d need %0d", f, q_bin.size(), rows * width);
      end
      for (int k = 0; k < q_bin.size() && k < rows * width; k++) begin
        int r; int c; int n; logic eb;
        r = k / width; c = k % width; n = win_count(r, c); eb = exp_bin(m, r, c);
        n_assert++;
        if (q_bin[k] !== eb) begin n_fail++; $display("FAIL random_bin f%0d m%0d r%0d c%0d got %b need %b", f, m, r, c, q_bin[k], eb); end
        n_assert++;
        if (q_cnt[k] !== exp_cnt(n)) begin n_fail++; $display("FAIL random_cnt f%0d r%0d c%0d got %0d need %0d", f, r, c, q_cnt[k], exp_cnt(n)); end
        n_assert++;
        if (q_ge[k] !== exp_ge(n, th)) begin n_fail++; $display("FAIL random_ge f%0d r%0d c%0d got %b need %b", f, r, c, q_ge[k], exp_ge(n, th)); end
      end
    end
  endtask

  task automatic test_overflow();
    int m;
    vsync = 1'b1; vde = 1'b0;
    step();
    vsync = 1'b0;
    step();
    step();
    for (int p = 1; p <= 10; p++) begin
      logic want;
      want = (p >= 9);
      vde = 1'b1; bin_in = 1'($urandom);
      step();
      n_assert++;
      if (overflow !== want) begin n_fail++; $display("FAIL overflow_pixel %0d got %b need %b", p, overflow, want); end
    end
    vde = 1'b0;
    repeat (3) step();
    n_assert++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got %b need 1", overflow); end
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    n_assert++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear got %b need 0", overflow); end
    // The frame after the overflowed line must filter normally.
    foreach (img[r, c]) img[r][c] = 1'($urandom);
    m = $urandom_range(0, 3);
    mode = 2'(m); thresh = 4'd4;
    drive_frame(8, 8);
    n_assert++;
    if (q_bin.size() != 64) begin
      n_fail++; $display("FAIL after_ovf_len got %0d need 64", q_bin.size());
    end
    for (int k = 0; k < q_bin.size() && k < 64; k++) begin
      int r; int c; int n; logic eb;
      r = k / 8; c = k % 8; n = win_count(r, c); eb = exp_bin(m, r, c);
      n_assert++;
      if (q_bin[k] !== eb) begin n_fail++; $display("FAIL after_ovf_bin r%0d c%0d got %b need %b", r, c, q_bin[k], eb); end
      n_assert++;
      if (q_cnt[k] !== exp_cnt(n)) begin n_fail++; $display("FAIL after_ovf_cnt r%0d c%0d got %0d need %0d", r, c, q_cnt[k], exp_cnt(n)); end
    end
    n_assert++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL after_ovf_flag got %b need 0", overflow); end
  endtask

  initial begin
    RST_N = 1'b0; vsync = 1'b0; vde = 1'b0; bin_in = 1'b0;
    mode = 2'b00; thresh = '0;
    #2;
    test_reset();
    test_dilate();
    test_erode();
    test_edge();
    test_count_threshold();
    test_random_frames();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/image_window_filter.md
# image_window_filter

Parametrised streaming K×K binary neighbourhood filter for the video pipeline. It sits after a threshold stage and takes one binary pixel per VDE cycle. It holds K-1 lines in an internal line buffer and applies a runtime-selected morphological mode: pass, erode, dilate or edge. It generalises the fixed 3×3 blur and edge stages in width, window size and mode, and adds window popcount, count-threshold output, frame-start handling and overflow detection.

## Interface
- LINE_W, 1024: maximum active pixels per line (line buffer depth); power of two not required
- K, 3: window size; odd, 3..7
- CNT_W, $clog2(K*K+1): width of count and threshold
- CLK  in  1  pixel clock
- RST_N  in  1  asynchronous reset, active low
- vsync  in  1  single-cycle frame-start pulse
- vde  in  1  pixel valid (active video)
- bin_in  in  1  binary input pixel
- mode  in  2  00 pass, 01 erode, 10 dilate, 11 edge
- thresh  in  CNT_W  count threshold
- bin_out  out  1  mode result
- cnt_out  out  CNT_W  number of ones in window
- cnt_ge  out  1  cnt_out >= thresh
- out_valid  out  1  result valid
- overflow  out  1  sticky: a line exceeded LINE_W pixels

## Operation
- Line start: a rising edge of vde, i.e. vde high with vde low on the previous cycle.
- Column counter col:
  - Cleared to 0 at line start; increments on every vde cycle.
  - Saturates at LINE_W-1.
  - Pixels beyond LINE_W are dropped from the buffer and set overflow.
  - overflow clears only on vsync or reset.
- Row tracking:
  - vsync clears row to 0 and sets first_line.
  - At line start: if first_line, clear first_line (row stays 0); else row increments, saturating at K-1.
  - If vsync and line start coincide, vsync wins and the line is row 0.
- Line buffer, on each vde cycle at address col:
  - Read buf[0..K-2][col].
  - Write buf[0][col] <= bin_in and buf[i][col] <= old buf[i-1][col].
- Column vector:
  - The column vector is {bin_in, buf[0][col], …, buf[K-2][col]}, for rows r, r-1, …, r-K+1.
  - Entry j is forced to 0 when j > row (rows before frame start).
- Window register (K×K):
  - Shifts in the column vector on each vde cycle.
  - Cleared to all zeros at line start, giving a zero left border.
  - Holds when vde is low.
- Result for the window:
  - The window centre is the pixel at (r-H, c-H), where H = K/2.
  - pass: centre bit.
  - erode: AND of all K*K bits.
  - dilate: OR of all K*K bits.
  - edge: centre AND NOT erode.
- cnt_out = popcount of window; cnt_ge = cnt_out >= thresh (unsigned).
- mode and thresh are sampled at the output stage, so a change affects the next registered result.
- The rightmost H columns and bottom H rows of each frame are never emitted (stream lag); no flush.
- Line buffer contents are not reset; row masking makes this invisible.

## Timing
- Reset values: bin_out=0, cnt_out=0, cnt_ge=0, out_valid=0, overflow=0, col=0, row=0, first_line=1, window all zero.
- Latency: bin_in sampled at edge t enters the window at t+1; outputs are registered at t+2.
- out_valid = vde delayed by exactly 2 cycles.
- When out_valid=0, outputs hold their last value.
- Throughput: one pixel per cycle, no stalls, no backpressure.
- Reset mid-frame: the state above is restored; data until the next vsync is treated as starting at row 0.

## Configuration
- IMAGE_WINDOW_FILTER_COUNT_EN defined: popcount, cnt_out and cnt_ge are implemented as above.
- Undefined: popcount logic is removed, cnt_out ties to 0 and cnt_ge ties to 0; thresh is ignored.
- bin_out and all timing are unchanged either way.

## Structure
- Package image_filter_pkg holds:
  - mode encodings MODE_PASS, MODE_ERODE, MODE_DILATE, MODE_EDGE;
  - the 2-bit mode typedef;
  - a clog2 helper for CNT_W and the col width.
- One sub-module, window_line_buffer:
  - (K-1)×LINE_W bits, single read-modify-write port at col;
  - maps to block RAM;
  - no reset.
- The top level holds the counters, masking, window register and output stage.

## Test plan
All scenarios use K=3 and LINE_W=8.
- Reset: assert RST_N low with random inputs → all outputs 0 and overflow=0; release → out_valid follows vde by 2 cycles.
- Dilate, single 1 at (2,3) in an all-zero 8×8 frame → bin_out=1 for centres rows 1..3, cols 2..4 only; cnt_out=1 at those centres.
- Erode, all-ones 8×8 frame → bin_out=0 for centre row 0 and col 0, 1 for centres rows 1..6, cols 1..6; cnt_out=9 at interior.
- Edge, 4×4 ones square at rows 2..5, cols 2..5 → bin_out=1 on the square perimeter (12 pixels) and 0 at interior (3..4, 3..4).
- Count threshold, thresh=5, checkerboard frame → cnt_ge=1 only where cnt_out is 5 (interior centres of 1s); cnt_out alternates 4/5.
- Overflow: one line of 10 vde cycles → overflow=1 from the 9th pixel onward, and it stays 1 until vsync; the next frame filters correctly.
